// File: rtl/i2c_eeprom_slave.sv
// I2C slave emulating a 256-byte 24C02-style EEPROM with a one-byte word address.
// SCL/SDA are oversampled on clk; SDA is only ever pulled low via sda_oe.
module i2c_eeprom_slave #(
  parameter logic [6:0] ADDRESS   = 7'b1010000,
  parameter int         MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe,
  output logic busy
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, ACK_DEV, WORD_ADDR, ACK_WORD,
    WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT_STOP
  } state_e;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start, stop;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       ack_on_q, ack_on_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       we;
  logic [7:0] byte_in, rd_byte;
  logic [7:0] mem_q [MEM_DEPTH];

  // Synchronizers reset to 1 so an idle bus produces no spurious edges
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s    = scl_sync_q[1];
  assign sda_s    = sda_sync_q[1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start    = scl_s & ~sda_s & sda_prev_q;
  assign stop     = scl_s & sda_s & ~sda_prev_q;
  assign byte_in  = {shift_q[6:0], sda_s};
  assign rd_byte  = mem_q[ptr_q];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    ack_on_d = ack_on_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    we       = 1'b0;
    if (stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      ack_on_d = 1'b0;
    end else if (start) begin
      state_d  = DEV_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      ack_on_d = 1'b0;
    end else begin
      unique case (state_q)
        DEV_ADDR, WORD_ADDR, WR_DATA: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              if (state_q == WORD_ADDR) begin
                ptr_d   = byte_in;
                state_d = ACK_WORD;
              end else if (state_q == WR_DATA) begin
                we      = 1'b1;
                ptr_d   = ptr_q + 8'd1;
                state_d = ACK_WR;
              end else if (byte_in[7:1] == ADDRESS) begin
                rw_d    = byte_in[0];
                state_d = ACK_DEV;
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end
        end
        // First fall pulls the ACK, second fall ends it
        ACK_DEV, ACK_WORD, ACK_WR: begin
          if (scl_fall) begin
            ack_on_d = ~ack_on_q;
            sda_oe_d = ~ack_on_q;
            if (!ack_on_q) begin
              busy_d = busy_q | (state_q == ACK_DEV);
            end else if (state_q != ACK_DEV) begin
              state_d = WR_DATA;
            end else if (!rw_q) begin
              state_d = WORD_ADDR;
            end else begin
              state_d  = RD_DATA;
              sda_oe_d = ~rd_byte[7];
              shift_d  = {rd_byte[6:0], 1'b0};
              cnt_d    = 4'd1;
            end
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = RD_ACK;
            end else if (cnt_q == 4'd0) begin
              sda_oe_d = ~rd_byte[7];
              shift_d  = {rd_byte[6:0], 1'b0};
              cnt_d    = 4'd1;
            end else begin
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ptr_d = ptr_q + 8'd1;
            if (sda_s) begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end else begin
              state_d = RD_DATA;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      ptr_q    <= '0;
      rw_q     <= 1'b0;
      ack_on_q <= 1'b0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      ptr_q    <= ptr_d;
      rw_q     <= rw_d;
      ack_on_q <= ack_on_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[ptr_q] <= byte_in;
    end
  end

  assign sda_oe = sda_oe_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bit-banged I2C master with a scoreboarded bus monitor and an EEPROM model.
// Slave-driven bits (ACKs, read data) are queued as expectations and checked.
module tb_i2c_eeprom_slave;

  localparam int Q = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic slot = 1'b0;
  logic sda_oe, busy, sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_eeprom_slave dut (
    .clk   (clk),
    .rst   (rst),
    .scl_i (scl_m),
    .sda_i (sda_bus),
    .sda_oe(sda_oe),
    .busy  (busy)
  );

  typedef struct {
    string      tag;
    int         nbits;
    logic [7:0] val;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] mdl_mem [256];
  logic [7:0] mdl_ptr;
  logic [7:0] wbuf [8];

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int nb,
                          input logic [7:0] v);
    exp_t e;
    e.tag   = tag;
    e.nbits = nb;
    e.val   = v;
    sb_q.push_back(e);
  endtask

  // Monitor: samples SDA mid-high on every slave-driven clock
  initial begin
    logic [7:0] acc;
    int         n;
    exp_t       e;
    acc = '0;
    n   = 0;
    forever begin
      @(posedge scl_m);
      if (slot) begin
        #(Q);
        acc = {acc[6:0], sda_bus};
        n++;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty: got bit %0b want no slave bit", sda_bus);
          acc = '0;
          n   = 0;
        end else if (n == sb_q[0].nbits) begin
          e = sb_q.pop_front();
          chk(e.tag, acc, e.val);
          acc = '0;
          n   = 0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic bit_cycle(input logic b);
    sda_m = b;
    #(Q);
    scl_m = 1'b1;
    #(2*Q);
    scl_m = 1'b0;
    #(Q);
  endtask

  task automatic do_start;
    sda_m = 1'b1;
    #(Q);
    scl_m = 1'b1;
    #(Q);
    sda_m = 1'b0;
    #(Q);
    scl_m = 1'b0;
    #(Q);
  endtask

  task automatic do_stop;
    sda_m = 1'b0;
    #(Q);
    scl_m = 1'b1;
    #(Q);
    sda_m = 1'b1;
    #(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic nack,
                           input string tag);
    for (int i = 7; i >= 0; i--) bit_cycle(b[i]);
    push_exp(tag, 1, {7'b0, nack});
    slot = 1'b1;
    bit_cycle(1'b1);
    slot = 1'b0;
  endtask

  task automatic read_byte(input logic last);
    push_exp($sformatf("rd@%02h", mdl_ptr), 8, mdl_mem[mdl_ptr]);
    mdl_ptr = mdl_ptr + 8'd1;
    slot = 1'b1;
    repeat (8) bit_cycle(1'b1);
    slot = 1'b0;
    bit_cycle(last);
  endtask

  task automatic read_bytes(input int n);
    for (int i = 0; i < n; i++) read_byte(i == n - 1);
    chk("rel_nack", {7'b0, sda_oe}, 8'h00);
    chk("busy_nack", {7'b0, busy}, 8'h00);
  endtask

  task automatic write_txn(input logic [7:0] addr, input int len);
    do_start;
    send_byte(8'hA0, 1'b0, "ack_dev_w");
    chk("busy_w", {7'b0, busy}, 8'h01);
    send_byte(addr, 1'b0, "ack_word");
    mdl_ptr = addr;
    for (int i = 0; i < len; i++) begin
      send_byte(wbuf[i], 1'b0, "ack_wr");
      mdl_mem[mdl_ptr] = wbuf[i];
      mdl_ptr = mdl_ptr + 8'd1;
    end
    do_stop;
    chk("busy_stop", {7'b0, busy}, 8'h00);
  endtask

  task automatic rand_read(input logic [7:0] addr, input int len);
    do_start;
    send_byte(8'hA0, 1'b0, "ack_dev_w");
    send_byte(addr, 1'b0, "ack_word");
    mdl_ptr = addr;
    do_start;
    send_byte(8'hA1, 1'b0, "ack_dev_r");
    read_bytes(len);
    do_stop;
  endtask

  task automatic cur_read(input int len);
    do_start;
    send_byte(8'hA1, 1'b0, "ack_dev_r");
    read_bytes(len);
    do_stop;
  endtask

  initial begin
    logic [7:0] a;
    int         len;
    for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
    mdl_ptr = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sda_oe", {7'b0, sda_oe}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    #(4*Q);

    wbuf[0] = 8'h5A;
    write_txn(8'h10, 1);
    rand_read(8'h10, 1);

    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    wbuf[2] = 8'h33;
    write_txn(8'hFE, 3);
    rand_read(8'hFE, 3);

    do_start;
    send_byte(8'hA2, 1'b1, "ack_mismatch");
    chk("busy_mismatch", {7'b0, busy}, 8'h00);
    do_stop;
    wbuf[0] = 8'(($urandom));
    write_txn(8'h40, 1);
    rand_read(8'h40, 1);

    cur_read(2);

    for (int it = 0; it < 6; it++) begin
      a   = (it == 0) ? 8'hFD : 8'($urandom_range(0, 255));
      len = int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) wbuf[i] = 8'($urandom);
      write_txn(a, len);
      rand_read(a, len);
      cur_read(int'($urandom_range(1, 2)));
    end

    wbuf[0] = 8'h5A;
    write_txn(8'h10, 1);
    do_start;
    send_byte(8'hA0, 1'b0, "ack_dev_w");
    send_byte(8'h10, 1'b0, "ack_word");
    do_start;
    send_byte(8'hA1, 1'b0, "ack_dev_r");
    chk("drive_zero", {7'b0, sda_oe}, 8'h01);
    chk("busy_read", {7'b0, busy}, 8'h01);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_sda_oe", {7'b0, sda_oe}, 8'h00);
    chk("rst_mid_busy", {7'b0, busy}, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
    mdl_ptr = 8'h00;
    do_stop;
    rand_read(8'h10, 1);

    wbuf[0] = 8'h77;
    write_txn(8'h20, 1);
    do_start;
    send_byte(8'hA0, 1'b0, "ack_dev_w");
    send_byte(8'h20, 1'b0, "ack_word");
    for (int i = 7; i >= 4; i--) bit_cycle(a[i] ^ 1'b1);
    do_stop;
    chk("stop_sda_oe", {7'b0, sda_oe}, 8'h00);
    chk("stop_busy", {7'b0, busy}, 8'h00);
    rand_read(8'h20, 1);
    cur_read(1);

    #(4*Q);
    chk("sb_drain", 8'(sb_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
